// File: rtl/lut_wvf_sequencer.sv
// lut_wvf_sequencer
//   Controller for one LUT_WVF_GEN instance running in external-trigger mode.
//   It produces the generator enable and the per-sample advance pulse from a
//   runtime prescaler. It also counts complete waveform repetitions, inserts
//   idle gaps between them, and gives a START/BUSY/DONE handshake.
//
//   Optional build macro: LUT_SEQ_RETRIGGER_EN
//     defined   : START in RUN or GAP (without ABORT) relatches the config,
//                 clears REP_CNT and the prescaler, drops LUT_EN for exactly
//                 one cycle, then resumes RUN. No DONE is issued for the
//                 interrupted sequence.
//     undefined : START while busy is ignored.
//
// Ports
//   CLK_SYS   system clock
//   RST       synchronous active-high reset
//   START     start request (IDLE only, unless retrigger is built in)
//   ABORT     stop immediately; highest priority
//   PRESCALE  CLK_SYS cycles per LUT sample (0 treated as 1)
//   NUM_REP   repetitions per sequence (0 = continuous until ABORT)
//   GAP_CYC   idle cycles between repetitions (0 = back-to-back)
//   LUT_END   generator index is at its last entry
//   LUT_EN    generator enable; low returns the generator index to 0
//   LUT_TRGG  one-cycle sample advance pulse to the generator
//   BUSY      high in RUN, GAP and DONE
//   DONE      one-cycle pulse on normal completion
//   REP_CNT   completed repetitions in the current sequence

module lut_wvf_sequencer #(
    parameter int PRE_WIDTH = 12,
    parameter int REP_WIDTH = 8,
    parameter int GAP_WIDTH = 16
) (
    input  logic                 CLK_SYS,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [PRE_WIDTH-1:0] PRESCALE,
    input  logic [REP_WIDTH-1:0] NUM_REP,
    input  logic [GAP_WIDTH-1:0] GAP_CYC,
    input  logic                 LUT_END,
    output logic                 LUT_EN,
    output logic                 LUT_TRGG,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [REP_WIDTH-1:0] REP_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t               state;
    logic [PRE_WIDTH-1:0] pre_lat;
    logic [REP_WIDTH-1:0] nrep_lat;
    logic [GAP_WIDTH-1:0] gap_lat;
    logic [PRE_WIDTH-1:0] pre_cnt;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic [REP_WIDTH-1:0] rep_cnt;
    logic                 lut_en_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 load_cfg;
    logic                 trgg;
    logic                 rep_end;
    logic                 last_rep;

`ifdef LUT_SEQ_RETRIGGER_EN
    assign load_cfg = START && !ABORT &&
                      (state == ST_IDLE || state == ST_RUN || state == ST_GAP);
`else
    assign load_cfg = START && !ABORT && (state == ST_IDLE);
`endif

    assign trgg     = (state == ST_RUN) && (pre_cnt == pre_lat - PRE_WIDTH'(1));
    assign rep_end  = trgg && LUT_END;
    // Widened compare so a saturated count cannot wrap into a false match.
    assign last_rep = (nrep_lat != '0) &&
                      (({1'b0, rep_cnt} + (REP_WIDTH+1)'(1)) == {1'b0, nrep_lat});

    // Latched configuration; inputs are ignored between loads.
    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            pre_lat  <= '0;
            nrep_lat <= '0;
            gap_lat  <= '0;
        end else if (load_cfg) begin
            pre_lat  <= (PRESCALE == '0) ? PRE_WIDTH'(1) : PRESCALE;
            nrep_lat <= NUM_REP;
            gap_lat  <= GAP_CYC;
        end
    end

    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            state    <= ST_IDLE;
            pre_cnt  <= '0;
            gap_cnt  <= '0;
            rep_cnt  <= '0;
            lut_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (ABORT) begin
            state    <= ST_IDLE;
            lut_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (load_cfg && state != ST_IDLE) begin
            // Retrigger: a one-cycle pass through GAP drops LUT_EN once so
            // the generator restarts from index 0.
            state    <= ST_GAP;
            gap_cnt  <= GAP_WIDTH'(1);
            pre_cnt  <= '0;
            rep_cnt  <= '0;
            lut_en_q <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_cfg) begin
                        state    <= ST_RUN;
                        pre_cnt  <= '0;
                        rep_cnt  <= '0;
                        lut_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (trgg) begin
                        pre_cnt <= '0;
                    end else begin
                        pre_cnt <= pre_cnt + PRE_WIDTH'(1);
                    end
                    if (rep_end) begin
                        if (rep_cnt != '1) begin
                            rep_cnt <= rep_cnt + REP_WIDTH'(1);
                        end
                        if (last_rep) begin
                            state    <= ST_DONE;
                            lut_en_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else if (gap_lat != '0) begin
                            state    <= ST_GAP;
                            gap_cnt  <= gap_lat;
                            lut_en_q <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    // gap_cnt counts down; the cycle holding 1 is the last one.
                    if (gap_cnt <= GAP_WIDTH'(1)) begin
                        state    <= ST_RUN;
                        pre_cnt  <= '0;
                        lut_en_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    lut_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign LUT_EN   = lut_en_q;
    assign LUT_TRGG = trgg;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign REP_CNT  = rep_cnt;

endmodule
